// File: rtl/sort_dma_pkg.sv
// Shared types and defaults for the sort DMA engine.
package sort_dma_pkg;

  localparam int DEPTH_DEF  = 32;
  localparam int IDX_W_DEF  = 5;
  localparam int LEN_W_DEF  = 6;
  localparam int XLEN_DEF   = 32;
  // A word index becomes a byte offset by shifting left this many bits.
  localparam int WORD_SHIFT = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_REQ,
    LOAD_WR,
    START,
    SORT_WAIT,
    STORE_RD,
    STORE_REQ,
    FINISH
  } state_t;

endpackage

// File: rtl/sort_dma_engine.sv
// Command-driven copy engine: data memory -> sorter memory, run the sorter,
// then sorter memory -> data memory at the same addresses.
module sort_dma_engine
  import sort_dma_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int IDX_W   = IDX_W_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int XLEN    = XLEN_DEF,
  parameter int TIMEOUT = 4096
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [XLEN-1:0]  cmd_base,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [XLEN-1:0]  dmem_addr,
  output logic [XLEN-1:0]  dmem_wdata,
  input  logic             dmem_gnt,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic             acc_we,
  output logic [IDX_W-1:0] acc_addr,
  output logic [XLEN-1:0]  acc_wdata,
  input  logic [XLEN-1:0]  acc_rdata,
  output logic             acc_start,
  output logic [LEN_W-1:0] acc_len,
  input  logic             acc_done,
  output logic             busy,
  output logic             done_pulse,
  output logic             err
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_t           state, state_nx;
  logic [XLEN-1:0]  base_q;
  logic [LEN_W-1:0] len_q;
  // Index kept at LEN_W bits so a full-depth run never wraps early.
  logic [LEN_W-1:0] idx_q;
  logic             err_q;
  logic [TMO_W-1:0] tmo_q;
  // Store-back word captured from the sorter memory, with its valid flag.
  logic [XLEN-1:0]  hold_p1;
  logic             vld_p1;

  logic             bad_cmd;
  logic             last_word;
  logic             wait_first;
  logic [XLEN-1:0]  word_addr;
  logic [XLEN-1:0]  store_data;

  assign bad_cmd    = (cmd_len > LEN_W'(DEPTH)) || (|cmd_base[WORD_SHIFT-1:0]);
  assign last_word  = (idx_q == len_q - LEN_W'(1));
  assign wait_first = (tmo_q == '0);
  assign word_addr  = base_q + (XLEN'(idx_q) << WORD_SHIFT);
  // First STORE_REQ cycle forwards the RAM output; later stalled cycles use
  // the captured copy so the write data stays put while the RAM index moves.
  assign store_data = vld_p1 ? hold_p1 : acc_rdata;
  assign acc_len    = len_q;

  // State register; reset aborts any run immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and output decode.
  always_comb begin
    state_nx   = state;
    cmd_ready  = 1'b0;
    busy       = 1'b1;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    acc_we     = 1'b0;
    acc_addr   = '0;
    acc_wdata  = '0;
    acc_start  = 1'b0;
    done_pulse = 1'b0;
    err        = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          if (bad_cmd || (cmd_len == '0)) state_nx = FINISH;
          else                            state_nx = LOAD_REQ;
        end
      end
      LOAD_REQ: begin
        dmem_req  = 1'b1;
        dmem_addr = word_addr;
        if (dmem_gnt) state_nx = LOAD_WR;
      end
      LOAD_WR: begin
        acc_we    = 1'b1;
        acc_addr  = idx_q[IDX_W-1:0];
        acc_wdata = dmem_rdata;
        state_nx  = last_word ? START : LOAD_REQ;
      end
      START: begin
        acc_start = 1'b1;
        state_nx  = SORT_WAIT;
      end
      SORT_WAIT: begin
        // The first wait cycle may still see done from the previous run.
        if (!wait_first && acc_done) state_nx = STORE_RD;
        else if (tmo_q == TMO_LAST)  state_nx = FINISH;
      end
      STORE_RD: begin
        acc_addr = idx_q[IDX_W-1:0];
        state_nx = STORE_REQ;
      end
      STORE_REQ: begin
        dmem_req   = 1'b1;
        dmem_we    = 1'b1;
        dmem_addr  = word_addr;
        dmem_wdata = store_data;
        if (dmem_gnt) state_nx = last_word ? FINISH : STORE_RD;
      end
      FINISH: begin
        done_pulse = 1'b1;
        err        = err_q;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Command latch, word index, timeout counter, error flag and store hold.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      base_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
      hold_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            base_q <= cmd_base;
            len_q  <= cmd_len;
            idx_q  <= '0;
            err_q  <= bad_cmd;
          end
        end
        LOAD_WR: begin
          idx_q <= last_word ? '0 : idx_q + LEN_W'(1);
        end
        START: begin
          tmo_q <= '0;
        end
        SORT_WAIT: begin
          tmo_q <= tmo_q + TMO_W'(1);
          if (state_nx == FINISH) err_q <= 1'b1;
        end
        STORE_RD: begin
          vld_p1 <= 1'b0;
        end
        STORE_REQ: begin
          if (!vld_p1) begin
            hold_p1 <= acc_rdata;
            vld_p1  <= 1'b1;
          end
          if (dmem_gnt && !last_word) idx_q <= idx_q + LEN_W'(1);
        end
        FINISH: begin
          err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_dma_engine.sv
// Directed bench for sort_dma_engine with data-memory and sorter models.
module tb_sort_dma_engine;

  localparam int SORT_W = 5;

  typedef logic [31:0] arr32_t [32];
  typedef logic [31:0] mem_t [256];

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_base = '0;
  logic [5:0]  cmd_len = '0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_gnt = 1'b1;
  logic [31:0] dmem_rdata = '0;
  logic        acc_we;
  logic [4:0]  acc_addr;
  logic [31:0] acc_wdata;
  logic [31:0] acc_rdata = '0;
  logic        acc_start;
  logic [5:0]  acc_len;
  logic        acc_done;
  logic        busy, done_pulse, err;

  always #5 clock = ~clock;

  sort_dma_engine #(
    .DEPTH(32), .IDX_W(5), .LEN_W(6), .XLEN(32), .TIMEOUT(16)
  ) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base(cmd_base), .cmd_len(cmd_len),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rdata(dmem_rdata),
    .acc_we(acc_we), .acc_addr(acc_addr), .acc_wdata(acc_wdata),
    .acc_rdata(acc_rdata), .acc_start(acc_start), .acc_len(acc_len),
    .acc_done(acc_done), .busy(busy), .done_pulse(done_pulse), .err(err)
  );

  // Initial data-memory image; each test uses its own region.
  function automatic mem_t init_image();
    mem_t m;
    for (int k = 0; k < 256; k++) m[k] = 32'hdead_0000 | 32'(k);
    m[8'h40] = 9;  m[8'h41] = 3;  m[8'h42] = 7;  m[8'h43] = 1;
    for (int k = 0; k < 32; k++) m[8'h80 + k] = 32'(31 - k);
    m[8'hc0] = 5;  m[8'hc1] = 4;  m[8'hc2] = 3;  m[8'hc3] = 2;
    m[8'h50] = 8;  m[8'h51] = 6;  m[8'h52] = 4;  m[8'h53] = 2;
    m[8'h60] = 40; m[8'h61] = 10; m[8'h62] = 30; m[8'h63] = 20;
    return m;
  endfunction

  function automatic arr32_t sorted_prefix(arr32_t a, int n);
    arr32_t r;
    logic [31:0] t;
    r = a;
    for (int x = 0; x < n; x++)
      for (int y = 0; y < n - 1 - x; y++)
        if (r[y] > r[y+1]) begin t = r[y]; r[y] = r[y+1]; r[y+1] = t; end
    return r;
  endfunction

  // Data memory: granted read returns data next cycle, granted write lands.
  mem_t dmem;
  logic mem_init = 1'b0;
  always @(posedge clock) begin
    if (!mem_init) begin
      dmem     <= init_image();
      mem_init <= 1'b1;
    end else if (dmem_req && dmem_gnt) begin
      if (dmem_we) dmem[dmem_addr[9:2]] <= dmem_wdata;
      else         dmem_rdata <= dmem[dmem_addr[9:2]];
    end
  end

  // Sorter: 1-cycle read RAM; done (level) rises SORT_W cycles after start,
  // and a done left from the previous run stays high one cycle past start.
  arr32_t acc_mem;
  logic   done_q = 1'b0;
  logic   run = 1'b0;
  logic   sorter_en = 1'b1;
  int     cnt = 0;
  always @(posedge clock) begin
    if (acc_we) acc_mem[acc_addr] <= acc_wdata;
    acc_rdata <= acc_mem[acc_addr];
    if (acc_start) begin
      run <= 1'b1;
      cnt <= 1;
    end else if (run) begin
      cnt <= cnt + 1;
      if (cnt == SORT_W - 1) begin
        acc_mem <= sorted_prefix(acc_mem, int'(acc_len));
        done_q  <= 1'b1;
        run     <= 1'b0;
      end else begin
        done_q <= 1'b0;
      end
    end
  end
  assign acc_done = done_q & sorter_en;

  // Grant: tied high, or about 30% random.
  logic gnt_rand = 1'b0;
  always @(negedge clock)
    dmem_gnt <= gnt_rand ? ($urandom_range(0, 9) < 3) : 1'b1;

  // Traffic and timing monitor.
  int   cyc = 0, accept_cyc = 0, done_cyc = 0, done_cnt = 0, start_cnt = 0;
  int   rd_cnt = 0, wr_cnt = 0, req_cyc = 0, viol = 0;
  logic last_err = 1'b0, st_prev = 1'b0, p_we = 1'b0;
  logic start_d = 1'b0, first_wait_done = 1'b0;
  logic [31:0] p_addr = '0, p_wdata = '0;
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (cmd_valid && cmd_ready) accept_cyc <= cyc;
    if (done_pulse) begin
      done_cyc <= cyc;
      done_cnt <= done_cnt + 1;
      last_err <= err;
    end
    if (acc_start) start_cnt <= start_cnt + 1;
    start_d <= acc_start;
    if (start_d) first_wait_done <= acc_done;
    if (dmem_req) req_cyc <= req_cyc + 1;
    if (dmem_req && dmem_gnt) begin
      if (dmem_we) wr_cnt <= wr_cnt + 1;
      else         rd_cnt <= rd_cnt + 1;
    end
    st_prev <= dmem_req && !dmem_gnt;
    p_addr  <= dmem_addr;
    p_we    <= dmem_we;
    p_wdata <= dmem_wdata;
    if (st_prev && !(dmem_req && dmem_addr == p_addr && dmem_we == p_we &&
                     dmem_wdata == p_wdata))
      viol <= viol + 1;
  end

  int total = 0;
  int bad = 0;
  int s_rd, s_wr, s_req, s_st, s_dn;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_rd = rd_cnt; s_wr = wr_cnt; s_req = req_cyc; s_st = start_cnt; s_dn = done_cnt;
  endtask

  task automatic issue(input logic [31:0] b, input logic [5:0] l);
    @(negedge clock);
    cmd_base  = b;
    cmd_len   = l;
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int k = 0;
    while (done_cnt == s_dn && k < limit) begin
      @(negedge clock);
      k++;
    end
    @(negedge clock);
    check(tag, done_cnt, s_dn + 1);
  endtask

  initial begin
    #400_000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clock);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_dmem_req", dmem_req, 0);
    check("rst_dmem_addr", dmem_addr, 0);
    check("rst_acc_start", acc_start, 0);
    check("rst_done_err", {done_pulse, err}, 0);
    check("rst_acc_len", acc_len, 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // 1: load and sort four words
    snap();
    issue(32'h100, 6'd4);
    wait_done("t1_done", 200);
    check("t1_mem0", dmem[8'h40], 1);
    check("t1_mem1", dmem[8'h41], 3);
    check("t1_mem2", dmem[8'h42], 7);
    check("t1_mem3", dmem[8'h43], 9);
    check("t1_starts", start_cnt - s_st, 1);
    check("t1_err", last_err, 0);
    check("t1_latency", done_cyc - accept_cyc, 23);
    check("t1_reads", rd_cnt - s_rd, 4);
    check("t1_writes", wr_cnt - s_wr, 4);
    check("t1_idle", cmd_ready, 1);

    // 2: zero length
    snap();
    issue(32'h100, 6'd0);
    wait_done("t2_done", 20);
    check("t2_latency", done_cyc - accept_cyc, 1);
    check("t2_err", last_err, 0);
    check("t2_req", req_cyc - s_req, 0);
    check("t2_start", start_cnt - s_st, 0);

    // 3: bad length, then misaligned base
    snap();
    issue(32'h100, 6'd33);
    wait_done("t3a_done", 20);
    check("t3a_err", last_err, 1);
    check("t3a_latency", done_cyc - accept_cyc, 1);
    check("t3a_req", req_cyc - s_req, 0);
    snap();
    issue(32'h102, 6'd4);
    wait_done("t3b_done", 20);
    check("t3b_err", last_err, 1);
    check("t3b_req", req_cyc - s_req, 0);
    check("t3b_start", start_cnt - s_st, 0);

    // 4: full depth, reverse data, random grant stalls
    snap();
    gnt_rand = 1'b1;
    issue(32'h200, 6'd32);
    wait_done("t4_done", 3000);
    gnt_rand = 1'b0;
    for (int k = 0; k < 32; k++)
      check($sformatf("t4_word%0d", k), dmem[8'h80 + k], 32'(k));
    check("t4_reads", rd_cnt - s_rd, 32);
    check("t4_writes", wr_cnt - s_wr, 32);
    check("t4_stable", viol, 0);
    check("t4_err", last_err, 0);

    // 5: sorter never finishes
    sorter_en = 1'b0;
    snap();
    issue(32'h300, 6'd4);
    wait_done("t5_done", 200);
    check("t5_err", last_err, 1);
    check("t5_latency", done_cyc - accept_cyc, 26);
    check("t5_writes", wr_cnt - s_wr, 0);
    check("t5_mem0", dmem[8'hc0], 5);
    check("t5_mem3", dmem[8'hc3], 2);
    @(negedge clock);
    check("t5_idle", {cmd_ready, busy}, 2'b10);
    sorter_en = 1'b1;

    // 6a: reset during the store of word 2
    snap();
    issue(32'h140, 6'd4);
    begin
      int k = 0;
      while (!(wr_cnt == s_wr + 2 && dmem_req && dmem_we) && k < 200) begin
        @(negedge clock);
        k++;
      end
    end
    check("t6_reached", wr_cnt - s_wr, 2);
    reset = 1'b0;
    #1;
    check("t6_async_out", {busy, dmem_req, dmem_we, acc_we, acc_start}, 0);
    check("t6_async_ready", cmd_ready, 1);
    repeat (3) @(negedge clock);
    check("t6_no_wr", wr_cnt - s_wr, 2);
    check("t6_no_done", done_cnt - s_dn, 0);
    check("t6_mem0", dmem[8'h50], 2);
    check("t6_mem1", dmem[8'h51], 4);
    check("t6_mem2", dmem[8'h52], 4);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // 6b: next run with stale done high from the aborted run
    snap();
    issue(32'h180, 6'd4);
    wait_done("t6b_done", 200);
    check("t6b_stale_seen", first_wait_done, 1);
    check("t6b_mem0", dmem[8'h60], 10);
    check("t6b_mem1", dmem[8'h61], 20);
    check("t6b_mem2", dmem[8'h62], 30);
    check("t6b_mem3", dmem[8'h63], 40);
    check("t6b_latency", done_cyc - accept_cyc, 23);
    check("t6b_err", last_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
